spm_seq_ctrl: RTL and testbench

- Sequencer for the serial-parallel multiplier (spm) datapath, the chain of carry-save adder cells with a parallel x operand, a serial y bit and a serial product bit p.
- Accepts operand pairs over a valid/ready interface and clears the datapath.
- Streams y serially for 2N cycles while holding x stable, and deserialises the product bits.
- Returns the 2N-bit product over a valid/ready interface. Sits between the bus-side requester and one spm instance.

---
 rtl/spm_seq_pkg.sv | 21 ++
 rtl/spm_ser_deser.sv | 63 ++++++
 rtl/spm_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_spm_seq_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_seq_pkg.sv
// Shared types and helpers for the serial-parallel multiplier sequencer.
package spm_seq_pkg;

  // Controller states, fixed 2-bit encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Legal range of the spm pipeline latency
  localparam int PIPE_LAT_MIN = 0;
  localparam int PIPE_LAT_MAX = 3;

  // Counter width able to hold 0 .. 2N+PIPE_LAT without wrapping
  function automatic int cnt_width(input int n, input int pipe_lat);
    return $clog2(2 * n + pipe_lat + 1);
  endfunction

endpackage

// File: rtl/spm_ser_deser.sv
// Serialises the y operand towards the spm and deserialises product bits from it.
module spm_ser_deser
  import spm_seq_pkg::*;
#(
  parameter int N      = 32,
  parameter int SIGNED = 0,
  parameter int CW     = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            clr_en,
  input  logic            shift_en,
  input  logic [CW-1:0]   cnt,
  input  logic [N-1:0]    b_q,
  input  logic            spm_p,
  output logic            spm_y,
  output logic [2*N-1:0]  prod
);

  localparam int IW = $clog2(N);
  localparam logic [CW-1:0] N_C     = CW'(N);
  localparam logic [CW-1:0] TWO_N_C = CW'(2 * N);

  logic [2*N-1:0] prod_q;
  logic [2*N-1:0] prod_d;
  logic [IW-1:0]  bit_idx;

  assign bit_idx = cnt[IW-1:0];
  assign prod    = prod_q;

  // y bit for the current count: operand bits, then the extension bits, then zeros
  always_comb begin
    spm_y = 1'b0;
    if (run) begin
      if (cnt < N_C) begin
        spm_y = b_q[bit_idx];
      end else if (cnt < TWO_N_C) begin
        spm_y = (SIGNED != 0) ? b_q[N-1] : 1'b0;
      end
    end
  end

  // Product shift register: clear wins, otherwise new bits enter at the top
  always_comb begin
    prod_d = prod_q;
    if (clr_en) begin
      prod_d = '0;
    end else if (shift_en) begin
      prod_d = {spm_p, prod_q[2*N-1:1]};
    end
  end

  // Product register state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer: accepts operands, clears and drives one spm, returns the 2N-bit product.
module spm_seq_ctrl
  import spm_seq_pkg::*;
#(
  parameter int N        = 32,
  parameter int SIGNED   = 0,
  parameter int PIPE_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  input  logic            abort,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  out_p,
  output logic [N-1:0]    spm_x,
  output logic            spm_y,
  output logic            spm_clr,
  input  logic            spm_p,
  output logic            busy
);

  localparam int CW = cnt_width(N, PIPE_LAT);
  localparam logic [CW-1:0] PL_C   = CW'(PIPE_LAT);
  localparam logic [CW-1:0] LAST_C = CW'(2 * N + PIPE_LAT - 1);

  if (PIPE_LAT < PIPE_LAT_MIN || PIPE_LAT > PIPE_LAT_MAX) begin : g_bad_pipe_lat
    $error("spm_seq_ctrl: PIPE_LAT outside the supported range");
  end

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run;
  logic          shift_en;

  // Next-state logic; abort takes precedence over finishing the run
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = CLEAR;
      CLEAR:   state_d = abort ? IDLE : RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_C) begin
          state_d = DONE;
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and run counter
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d = in_a;
          b_d = in_b;
        end
      end
      CLEAR:   cnt_d = '0;
      RUN:     cnt_d = cnt_q + CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Moore outputs plus the abort-driven datapath clear
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    run       = (state_q == RUN);
    spm_clr   = (state_q == CLEAR) || ((state_q == RUN) && abort);
    shift_en  = (state_q == RUN) && !abort && (cnt_q >= PL_C);
    spm_x     = a_q;
  end

  // State, operand and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  spm_ser_deser #(
    .N      (N),
    .SIGNED (SIGNED),
    .CW     (CW)
  ) u_ser_deser (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .clr_en   (spm_clr),
    .shift_en (shift_en),
    .cnt      (cnt_q),
    .b_q      (b_q),
    .spm_p    (spm_p),
    .spm_y    (spm_y),
    .prod     (out_p)
  );

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Bench for spm_seq_ctrl: an unsigned and a signed instance, each driving a behavioural spm.
module tb_spm_seq_ctrl;

  localparam int N  = 8;
  localparam int PL = 1;
  localparam int W  = 2 * N;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]        in_valid, in_ready, abort, out_valid, out_ready;
  logic [1:0]        spm_y, spm_clr, spm_p, busy;
  logic [1:0][N-1:0] in_a, in_b, spm_x;
  logic [1:0][W-1:0] out_p;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] sb_q[$];

  always #5 clk = ~clk;

  // Instance 0 is unsigned, instance 1 signed; each has its own spm model
  for (genvar g = 0; g < 2; g++) begin : g_inst
    spm_seq_ctrl #(.N(N), .SIGNED(g), .PIPE_LAT(PL)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_a      (in_a[g]),
      .in_b      (in_b[g]),
      .abort     (abort[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_p     (out_p[g]),
      .spm_x     (spm_x[g]),
      .spm_y     (spm_y[g]),
      .spm_clr   (spm_clr[g]),
      .spm_p     (spm_p[g]),
      .busy      (busy[g])
    );

    int         k;
    logic [W-1:0] ybits;
    logic       p_q;

    // Behavioural spm: bit k of x*y is ready one cycle after y bit k arrives
    always @(posedge clk or negedge rst) begin
      logic [W-1:0] ynew;
      logic [W-1:0] xext;
      logic [W-1:0] prod;
      if (!rst) begin
        k     <= 0;
        ybits <= '0;
        p_q   <= 1'b0;
      end else if (spm_clr[g]) begin
        k     <= 0;
        ybits <= '0;
        p_q   <= 1'b0;
      end else begin
        ynew = ybits;
        if (k < W) ynew[k] = spm_y[g];
        xext = (g == 1) ? {{N{spm_x[g][N-1]}}, spm_x[g]} : {{N{1'b0}}, spm_x[g]};
        prod = xext * ynew;
        p_q   <= (k < W) ? prod[k] : 1'b0;
        ybits <= ynew;
        if (k < W) k <= k + 1;
      end
    end
    assign spm_p[g] = p_q;
  end

  // Offer one operand pair in IDLE; returns at the negedge of the CLEAR cycle
  task automatic do_accept(input int idx, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    in_valid[idx] = 1'b1;
    in_a[idx]     = a;
    in_b[idx]     = b;
    @(posedge clk);
    @(negedge clk);
    in_valid[idx] = 1'b0;
  endtask

  // Wait (bounded) at negedges until out_valid is seen
  task automatic wait_valid(input int idx, input int budget, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid[idx]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in_valid  = '0;
    abort     = '0;
    out_ready = 2'b11;
    in_a      = '0;
    in_b      = '0;
    #23;
    n_checks++;
    if ({out_valid, busy, spm_y, spm_clr} !== 8'h00)
      $display("[TB] FAIL reset_ctrl_outputs: got %b, expected 00000000", {out_valid, busy, spm_y, spm_clr});
    else n_pass++;
    n_checks++;
    if (spm_x !== '0) $display("[TB] FAIL reset_spm_x: got %h, expected 0000", spm_x);
    else n_pass++;
    n_checks++;
    if (out_p !== '0) $display("[TB] FAIL reset_product_reg: got %h, expected 00000000", out_p);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 2'b11) $display("[TB] FAIL reset_in_ready: got %b, expected 11", in_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    int cyc;
    bit x_bad;
    logic [16:0] yrec;
    logic [W-1:0] exp_p;
    x_bad = 1'b0;
    yrec  = '0;
    out_ready[0] = 1'b1;
    do_accept(0, 8'd3, 8'd5);
    sb_q.push_back(16'd15);
    n_checks++;
    if ({busy[0], spm_clr[0]} !== 2'b11) $display("[TB] FAIL basic_clear_cycle: got busy,clr=%b, expected 11", {busy[0], spm_clr[0]});
    else n_pass++;
    cyc = 1;
    while (!out_valid[0] && cyc < 40) begin
      if (busy[0] && !spm_clr[0]) begin
        if (spm_x[0] !== 8'd3) x_bad = 1'b1;
        if (cyc >= 2 && cyc - 2 <= 16) yrec[cyc-2] = spm_y[0];
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc !== 19) $display("[TB] FAIL basic_latency: got %0d cycles, expected 19", cyc);
    else n_pass++;
    n_checks++;
    if (x_bad) $display("[TB] FAIL basic_spm_x_hold: got spm_x not constant 3, expected 3 throughout");
    else n_pass++;
    n_checks++;
    if (yrec !== 17'h00005) $display("[TB] FAIL basic_y_stream: got %h, expected 00005", yrec);
    else n_pass++;
    exp_p = sb_q.pop_front();
    n_checks++;
    if (out_p[0] !== exp_p) $display("[TB] FAIL basic_product: got %h, expected %h", out_p[0], exp_p);
    else n_pass++;
  endtask

  task automatic test_values();
    int idx_t [3] = '{0, 1, 1};
    logic [N-1:0] a_t [3] = '{8'hFF, 8'hFF, 8'h80};
    logic [N-1:0] b_t [3] = '{8'hFF, 8'hFF, 8'h7F};
    logic [W-1:0] p_t [3] = '{16'hFE01, 16'h0001, 16'hC080};
    int cyc;
    bit ok;
    logic [W-1:0] exp_p;
    for (int i = 0; i < 3; i++) begin
      do_accept(idx_t[i], a_t[i], b_t[i]);
      sb_q.push_back(p_t[i]);
      wait_valid(idx_t[i], 40, cyc, ok);
      exp_p = sb_q.pop_front();
      n_checks++;
      if (!ok) $display("[TB] FAIL values_timeout_%0d: got no out_valid, expected out_valid", i);
      else if (out_p[idx_t[i]] !== exp_p)
        $display("[TB] FAIL values_product_%0d: got %h, expected %h", i, out_p[idx_t[i]], exp_p);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok;
    bit p_bad, r_bad, v_bad;
    logic [W-1:0] exp_p;
    p_bad = 1'b0; r_bad = 1'b0; v_bad = 1'b0;
    out_ready[0] = 1'b0;
    do_accept(0, 8'd20, 8'd30);
    sb_q.push_back(16'd600);
    wait_valid(0, 40, cyc, ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL bp_timeout: got no out_valid, expected out_valid");
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'b1;
      in_a[0] = 8'd99;
      in_b[0] = 8'd99;
      if (out_p[0] !== 16'd600) p_bad = 1'b1;
      if (in_ready[0] !== 1'b0) r_bad = 1'b1;
      if (out_valid[0] !== 1'b1) v_bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (p_bad) $display("[TB] FAIL bp_product_stable: got changing out_p, expected 0258 held");
    else n_pass++;
    n_checks++;
    if (r_bad) $display("[TB] FAIL bp_in_ready: got in_ready=1 in DONE, expected 0");
    else n_pass++;
    n_checks++;
    if (v_bad) $display("[TB] FAIL bp_out_valid_held: got out_valid=0 while stalled, expected 1");
    else n_pass++;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    exp_p = sb_q.pop_front();
    n_checks++;
    if (out_p[0] !== exp_p) $display("[TB] FAIL bp_product: got %h, expected %h", out_p[0], exp_p);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({out_valid[0], in_ready[0], busy[0]} !== 3'b010)
      $display("[TB] FAIL bp_release_idle: got valid,ready,busy=%b, expected 010", {out_valid[0], in_ready[0], busy[0]});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy[0] !== 1'b0) $display("[TB] FAIL bp_no_latch: got busy=%b, expected 0", busy[0]);
    else n_pass++;
  endtask

  task automatic test_abort();
    int cyc;
    bit ok;
    bit seen;
    logic [W-1:0] exp_p;
    seen = 1'b0;
    do_accept(0, 8'd50, 8'd3);
    repeat (6) @(negedge clk);
    abort[0] = 1'b1;
    #1;
    n_checks++;
    if ({busy[0], spm_clr[0]} !== 2'b11) $display("[TB] FAIL abort_clr: got busy,clr=%b, expected 11", {busy[0], spm_clr[0]});
    else n_pass++;
    @(negedge clk);
    abort[0] = 1'b0;
    n_checks++;
    if ({busy[0], in_ready[0], spm_clr[0]} !== 3'b010)
      $display("[TB] FAIL abort_idle: got busy,ready,clr=%b, expected 010", {busy[0], in_ready[0], spm_clr[0]});
    else n_pass++;
    for (int i = 0; i < 30; i++) begin
      if (out_valid[0]) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen) $display("[TB] FAIL abort_no_output: got out_valid=1, expected 0");
    else n_pass++;
    do_accept(0, 8'd6, 8'd7);
    sb_q.push_back(16'd42);
    wait_valid(0, 40, cyc, ok);
    exp_p = sb_q.pop_front();
    n_checks++;
    if (!ok) $display("[TB] FAIL abort_next_timeout: got no out_valid, expected out_valid");
    else if (out_p[0] !== exp_p) $display("[TB] FAIL abort_next_product: got %h, expected %h", out_p[0], exp_p);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    bit seen;
    logic [W-1:0] exp_p;
    seen = 1'b0;
    do_accept(0, 8'd100, 8'd3);
    repeat (8) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({out_valid[0], busy[0], spm_y[0], spm_clr[0]} !== 4'b0000)
      $display("[TB] FAIL rstmid_outputs: got %b, expected 0000", {out_valid[0], busy[0], spm_y[0], spm_clr[0]});
    else n_pass++;
    n_checks++;
    if (spm_x[0] !== 8'h00) $display("[TB] FAIL rstmid_spm_x: got %h, expected 00", spm_x[0]);
    else n_pass++;
    @(negedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid[0] || busy[0]) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("[TB] FAIL rstmid_no_output: got activity after reset, expected idle");
    else n_pass++;
    do_accept(0, 8'd2, 8'd9);
    sb_q.push_back(16'd18);
    wait_valid(0, 40, cyc, ok);
    exp_p = sb_q.pop_front();
    n_checks++;
    if (!ok) $display("[TB] FAIL rstmid_next_timeout: got no out_valid, expected out_valid");
    else if (out_p[0] !== exp_p) $display("[TB] FAIL rstmid_next_product: got %h, expected %h", out_p[0], exp_p);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nacc, nres, res_cyc;
    int acc_cyc [2];
    bit pend;
    logic [W-1:0] exp_p;
    nacc = 0; nres = 0; res_cyc = -1; pend = 1'b0;
    acc_cyc[0] = -1; acc_cyc[1] = -1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_a[0] = 8'd10;
    in_b[0] = 8'd11;
    sb_q.push_back(16'd110);
    sb_q.push_back(16'd156);
    for (int cyc = 0; cyc < 100 && nres < 2; cyc++) begin
      if (pend) begin
        pend = 1'b0;
        if (nacc == 1) begin
          in_a[0] = 8'd12;
          in_b[0] = 8'd13;
        end else begin
          in_valid[0] = 1'b0;
        end
      end
      if (in_valid[0] && in_ready[0] && nacc < 2) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        pend = 1'b1;
      end
      if (out_valid[0]) begin
        if (nres == 0) res_cyc = cyc;
        n_checks++;
        if (sb_q.size() == 0) $display("[TB] FAIL b2b_extra_result: got %h, expected none", out_p[0]);
        else begin
          exp_p = sb_q.pop_front();
          if (out_p[0] !== exp_p) $display("[TB] FAIL b2b_product_%0d: got %h, expected %h", nres, out_p[0], exp_p);
          else n_pass++;
        end
        nres++;
      end
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    n_checks++;
    if (nres !== 2) $display("[TB] FAIL b2b_result_count: got %0d, expected 2", nres);
    else n_pass++;
    n_checks++;
    if (acc_cyc[1] !== res_cyc + 1)
      $display("[TB] FAIL b2b_second_accept: got cycle %0d, expected %0d", acc_cyc[1], res_cyc + 1);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy[0] !== 1'b0) $display("[TB] FAIL b2b_final_idle: got busy=%b, expected 0", busy[0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
